// File: rtl/global_types.sv
`default_nettype none
// ============================================================================
//  Module      : global_types (package)
//  Description : Types and constants shared by the fetch buffer and its FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package global_types;

    typedef logic [31:0] logic32;

    // One queued fetch result: the instruction word and the address after it
    typedef struct packed {
        logic32 instruction;
        logic32 pc_plus4;
    } fetch_entry_t;

    // Default first fetch address after reset
    localparam logic32 DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO of fetch entries with push, pop, flush,
//                entry count and head read without pop. Flush wins over push
//                and pop. The caller guarantees no push while full.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import global_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           data_i,
    input  logic                   pop_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            w_push, w_pop;

    assign w_push = push_i && !flush_i;
    assign w_pop  = pop_i && !flush_i && (count_q != '0);

    // Pointer and count update; pointers wrap naturally (DEPTH is a power of two)
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(w_push) - CW'(w_pop);
        end
    end

    // Control state register
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk_i) begin
        if (reset_ni && w_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer
//  Description : Instruction prefetch stage. Issues sequential fetches under a
//                credit limit, queues in-order memory responses and presents
//                them to decode with a valid/ready handshake. Redirects flush
//                the queue and drop responses still in flight.
//                Optional macro FETCH_BUF_BYPASS_EN: a response arriving into
//                an empty queue is presented to decode in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import global_types::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_valid,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    input  logic                   d_ready,
    output logic                   f_valid,
    output logic [31:0]            f_instruction,
    output logic [31:0]            f_pc_plus4,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int            CW           = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   c_credit_max = (CW + 1)'(DEPTH);

    logic [31:0]    pc_q, pc_d;
    logic [31:0]    resp_pc_q, resp_pc_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [CW-1:0]  discard_q, discard_d;

    fetch_entry_t   w_head, w_resp_entry, w_front;
    logic [CW-1:0]  w_count;
    logic [CW:0]    w_credit_sum;
    logic           w_issue, w_resp, w_drop, w_keep;
    logic           w_push, w_pop, w_fifo_nonempty;

    // Credit uses registered state only, so a pop this cycle frees nothing yet
    assign w_credit_sum    = {1'b0, w_count} + {1'b0, inflight_q};
    assign w_issue         = reset_n && !redirect && (w_credit_sum < c_credit_max);

    // A response with nothing outstanding is a protocol error and is ignored
    assign w_resp          = reset_n && imem_valid && (inflight_q != '0);
    assign w_drop          = w_resp && (redirect || (discard_q != '0));
    assign w_keep          = w_resp && !w_drop;
    assign w_fifo_nonempty = (w_count != '0);
    assign w_resp_entry    = '{instruction: imem_rdata, pc_plus4: resp_pc_q + 32'd4};
    assign w_pop           = reset_n && !redirect && w_fifo_nonempty && d_ready;

`ifdef FETCH_BUF_BYPASS_EN
    logic w_bypass;
    // A kept response into an empty queue goes straight to decode; stored only if not taken
    assign w_bypass = w_keep && !w_fifo_nonempty;
    assign w_push   = w_keep && !(w_bypass && d_ready);
    assign f_valid  = reset_n && !redirect && (w_fifo_nonempty || w_bypass);
    assign w_front  = w_fifo_nonempty ? w_head : w_resp_entry;
`else
    assign w_push   = w_keep;
    assign f_valid  = reset_n && !redirect && w_fifo_nonempty;
    assign w_front  = w_head;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .flush_i  (redirect),
        .push_i   (w_push),
        .data_i   (w_resp_entry),
        .pop_i    (w_pop),
        .head_o   (w_head),
        .count_o  (w_count)
    );

    assign imem_req      = w_issue;
    assign imem_addr     = reset_n ? pc_q : RESET_PC;
    assign f_instruction = reset_n ? w_front.instruction : '0;
    assign f_pc_plus4    = reset_n ? w_front.pc_plus4 : '0;
    assign occupancy     = reset_n ? w_count : '0;

    // Next-state for PCs, outstanding-request count and discard count
    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q + CW'(w_issue) - CW'(w_resp);
        discard_d  = discard_q;
        if (redirect) begin
            // Everything outstanding except a response landing now is stale
            pc_d      = redirect_pc;
            resp_pc_d = redirect_pc;
            discard_d = inflight_q - CW'(w_resp);
        end else begin
            if (w_issue) pc_d = pc_q + 32'd4;
            if (w_keep)  resp_pc_d = resp_pc_q + 32'd4;
            if (w_resp && (discard_q != '0)) discard_d = discard_q - CW'(1);
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!reset_n)
        !(imem_valid && (inflight_q == '0)));
    a_credit_cap: assert property (@(posedge clk) disable iff (!reset_n)
        w_credit_sum <= c_credit_max);
    a_discard_cap: assert property (@(posedge clk) disable iff (!reset_n)
        discard_q <= inflight_q);

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_buffer
//  Description : Self-checking bench for fetch_buffer: memory model with
//                programmable latency, in-order scoreboard of expected decode
//                entries, and directed scenario tasks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        d_ready = 1'b0;
    logic        f_valid;
    logic [31:0] f_instruction;
    logic [31:0] f_pc_plus4;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mem_lat  = 1;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc4; } exp_t;
    mreq_t       mq[$];
    exp_t        exp_q[$];
    logic [31:0] model_pc = 32'h0;

    fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .d_ready       (d_ready),
        .f_valid       (f_valid),
        .f_instruction (f_instruction),
        .f_pc_plus4    (f_pc_plus4),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'hA5C3_0F1E;
    endfunction

    // Memory model: deliver responses in order at their due cycle
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_rdata = memword(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_valid = 1'b0;
            imem_rdata = '0;
        end
    end

    // Monitor: request-address model, scoreboard push on issue, compare on pop
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            mq.delete();
            model_pc = 32'h0;
            n_checks++;
            if (imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL req_in_reset: imem_req=%b required 0", imem_req);
            end
        end else if (redirect) begin
            n_checks++;
            if (imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL req_on_redirect: imem_req=%b required 0", imem_req);
            end
            exp_q.delete();
            model_pc = redirect_pc;
        end else begin
            if (f_valid === 1'b1 && d_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: popped instr %h pc4 %h with nothing expected",
                             f_instruction, f_pc_plus4);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (f_instruction !== e.instr || f_pc_plus4 !== e.pc4) begin
                        n_fail++;
                        $display("FAIL sb_entry: got instr %h pc4 %h, required instr %h pc4 %h",
                                 f_instruction, f_pc_plus4, e.instr, e.pc4);
                    end
                end
            end
            if (imem_req === 1'b1) begin
                mreq_t m;
                exp_t  e;
                n_checks++;
                if (imem_addr !== model_pc) begin
                    n_fail++;
                    $display("FAIL req_addr: imem_addr=%h required %h", imem_addr, model_pc);
                end
                m.addr = imem_addr;
                m.due  = cyc + mem_lat;
                mq.push_back(m);
                e.instr = memword(imem_addr);
                e.pc4   = imem_addr + 32'd4;
                exp_q.push_back(e);
                model_pc = model_pc + 32'd4;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for the given number of edges, then release into cycle 0
    task automatic apply_reset(input int cycles, input int lat);
        next_cycle();
        reset_n  = 1'b0;
        redirect = 1'b0;
        mem_lat  = lat;
        repeat (cycles) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        next_cycle();
        reset_n = 1'b0;
        d_ready = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0)       begin n_fail++; $display("FAIL rst_req: %b required 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h0)     begin n_fail++; $display("FAIL rst_addr: %h required 0", imem_addr); end
        n_checks++; if (f_valid !== 1'b0)        begin n_fail++; $display("FAIL rst_fvalid: %b required 0", f_valid); end
        n_checks++; if (f_instruction !== 32'h0) begin n_fail++; $display("FAIL rst_finstr: %h required 0", f_instruction); end
        n_checks++; if (f_pc_plus4 !== 32'h0)    begin n_fail++; $display("FAIL rst_fpc4: %h required 0", f_pc_plus4); end
        n_checks++; if (occupancy !== 3'd0)      begin n_fail++; $display("FAIL rst_occ: %0d required 0", occupancy); end
    endtask

    task automatic test_stream();
        int first = -1;
`ifdef FETCH_BUF_BYPASS_EN
        int exp_first = 1;
`else
        int exp_first = 2;
`endif
        d_ready = 1'b1;
        apply_reset(2, 1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k < 3) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                    n_fail++;
                    $display("FAIL stream_req%0d: req %b addr %h required 1 %h", k, imem_req, imem_addr, 32'(4 * k));
                end
            end
            if (first >= 0) begin
                n_checks++;
                if (f_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_sustain: f_valid %b at cycle %0d required 1", f_valid, k);
                end
            end else if (f_valid === 1'b1) begin
                first = k;
                n_checks++;
                if (k != exp_first) begin n_fail++; $display("FAIL stream_first_cycle: %0d required %0d", k, exp_first); end
                n_checks++;
                if (f_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL stream_first_pc4: %h required 4", f_pc_plus4); end
            end
            next_cycle();
        end
        n_checks++;
        if (first < 0) begin n_fail++; $display("FAIL stream_timeout: no f_valid seen, required by cycle %0d", exp_first); end
    endtask

    task automatic test_backpressure();
        d_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (occupancy > 3'd4) begin n_fail++; $display("FAIL bp_occ_cap: %0d required <=4", occupancy); end
            next_cycle();
        end
        @(negedge clk);
        n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_occ_full: %0d required 4", occupancy); end
        n_checks++; if (imem_req !== 1'b0)  begin n_fail++; $display("FAIL bp_req_stall: %b required 0", imem_req); end
        next_cycle();
        d_ready = 1'b1;
        repeat (10) next_cycle();
    endtask

    task automatic test_redirect();
        bit got = 0;
        d_ready = 1'b1;
        apply_reset(1, 3);
        next_cycle();
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        n_checks++; if (f_valid !== 1'b0) begin n_fail++; $display("FAIL redir_fvalid: %b required 0", f_valid); end
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_first_req: req %b addr %h required 1 00000100", imem_req, imem_addr);
        end
        for (int k = 0; k < 20 && !got; k++) begin
            next_cycle();
            @(negedge clk);
            if (f_valid === 1'b1) begin
                got = 1;
                n_checks++;
                if (f_pc_plus4 !== 32'h104) begin n_fail++; $display("FAIL redir_pc4: %h required 00000104", f_pc_plus4); end
            end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL redir_timeout: no f_valid within 20 cycles"); end
        n_checks++;
        if (dut.discard_q !== '0) begin n_fail++; $display("FAIL redir_discard: %0d required 0", dut.discard_q); end
    endtask

    task automatic test_redirect_collide();
        d_ready = 1'b1;
        apply_reset(1, 1);
        repeat (4) next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        n_checks++;
        if (imem_valid !== 1'b1) begin n_fail++; $display("FAIL coll_setup: imem_valid %b required 1", imem_valid); end
        n_checks++;
        if (f_valid !== 1'b0) begin n_fail++; $display("FAIL coll_fvalid: %b required 0", f_valid); end
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL coll_req: req %b addr %h required 1 00000100", imem_req, imem_addr);
        end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL coll_occ: %0d required 0", occupancy); end
        n_checks++; if (f_valid !== 1'b0)   begin n_fail++; $display("FAIL coll_fvalid_next: %b required 0", f_valid); end
        repeat (6) next_cycle();
    endtask

    task automatic test_reset_mid();
        d_ready = 1'b0;
        apply_reset(1, 1);
        repeat (8) next_cycle();
        @(negedge clk);
        n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL rmid_full: %0d required 4", occupancy); end
        next_cycle();
        reset_n = 1'b0;
        d_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (f_valid !== 1'b0)        begin n_fail++; $display("FAIL rmid_fvalid: %b required 0", f_valid); end
        n_checks++; if (imem_addr !== 32'h0)     begin n_fail++; $display("FAIL rmid_addr: %h required 0", imem_addr); end
        n_checks++; if (f_instruction !== 32'h0) begin n_fail++; $display("FAIL rmid_finstr: %h required 0", f_instruction); end
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rmid_occ: %0d required 0", occupancy); end
        n_checks++; if (f_valid !== 1'b0)   begin n_fail++; $display("FAIL rmid_fvalid_after: %b required 0", f_valid); end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rmid_req: req %b addr %h required 1 00000000", imem_req, imem_addr);
        end
        repeat (6) next_cycle();
    endtask

    task automatic test_wrap();
        bit seen_top  = 0;
        bit seen_zero = 0;
        bit found     = 0;
        d_ready = 1'b1;
        apply_reset(1, 1);
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        next_cycle();
        redirect = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (imem_req === 1'b1 && imem_addr === 32'hFFFF_FFFC) seen_top = 1;
            if (seen_top && imem_req === 1'b1 && imem_addr === 32'h0) seen_zero = 1;
            if (f_valid === 1'b1 && f_instruction === memword(32'hFFFF_FFFC)) begin
                found = 1;
                n_checks++;
                if (f_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: %h required 0", f_pc_plus4); end
            end
            next_cycle();
        end
        n_checks++; if (seen_zero !== 1'b1) begin n_fail++; $display("FAIL wrap_req: no request to 0 after FFFFFFFC"); end
        n_checks++; if (found !== 1'b1)     begin n_fail++; $display("FAIL wrap_entry: entry for FFFFFFFC never presented"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_collide();
        test_reset_mid();
        test_wrap();
        d_ready = 1'b0;
        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
